// File: rtl/wb_regfile_stage_if.sv
// Writeback-stage bundle: MEM/WB inputs, decode-side read ports and the commit trace.
// master drives the MEM/WB fields and read addresses; slave is the writeback stage.
interface wb_regfile_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          memtoreg_i;
  logic          regwrite_i;
  logic [DW-1:0] result_i;
  logic [DW-1:0] finaldata_i;
  logic [AW-1:0] writereg_i;
  logic [31:0]   pc_i;
  logic [DW-1:0] hi_alu_out_i;
  logic [DW-1:0] lo_alu_out_i;
  logic [1:0]    hilo_we_i;
  logic [AW-1:0] raddr1_i;
  logic [AW-1:0] raddr2_i;
  logic [DW-1:0] rdata1_o;
  logic [DW-1:0] rdata2_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic [DW-1:0] wb_wdata_o;
  logic [31:0]   dbg_pc_o;
  logic [3:0]    dbg_wen_o;
  logic [AW-1:0] dbg_wnum_o;
  logic [DW-1:0] dbg_wdata_o;

  modport master (
    output memtoreg_i, regwrite_i, result_i, finaldata_i, writereg_i, pc_i,
           hi_alu_out_i, lo_alu_out_i, hilo_we_i, raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o, hi_o, lo_o, wb_wdata_o,
           dbg_pc_o, dbg_wen_o, dbg_wnum_o, dbg_wdata_o
  );

  modport slave (
    input  memtoreg_i, regwrite_i, result_i, finaldata_i, writereg_i, pc_i,
           hi_alu_out_i, lo_alu_out_i, hilo_we_i, raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o, hi_o, lo_o, wb_wdata_o,
           dbg_pc_o, dbg_wen_o, dbg_wnum_o, dbg_wdata_o
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage: GPR file + HI/LO with same-cycle bypass and a registered commit trace.
// Define WB_DEBUG_TRACE_EN to build the trace flops; otherwise dbg_* are tied to 0.
module wb_regfile_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_regfile_stage_if.slave bus
);
  localparam int NREG = 2 ** AW;

  logic [DW-1:0] gpr [NREG];
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic [DW-1:0] wdata;
  logic          commit;

  assign wdata  = bus.memtoreg_i ? bus.finaldata_i : bus.result_i;
  assign commit = bus.regwrite_i && (bus.writereg_i != '0);

  assign bus.wb_wdata_o = wdata;

  // ---- commit edge: GPR and HI/LO state ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (commit) gpr[bus.writereg_i] <= wdata;
      if (bus.hilo_we_i[1]) hi_q <= bus.hi_alu_out_i;
      if (bus.hilo_we_i[0]) lo_q <= bus.lo_alu_out_i;
    end
  end

  // r0 is forced to zero on read so the bypass can never leak a value into it
  always_comb begin
    bus.rdata1_o = gpr[bus.raddr1_i];
    bus.rdata2_o = gpr[bus.raddr2_i];
    if (commit && bus.raddr1_i == bus.writereg_i) bus.rdata1_o = wdata;
    if (commit && bus.raddr2_i == bus.writereg_i) bus.rdata2_o = wdata;
    if (bus.raddr1_i == '0) bus.rdata1_o = '0;
    if (bus.raddr2_i == '0) bus.rdata2_o = '0;
  end

  assign bus.hi_o = bus.hilo_we_i[1] ? bus.hi_alu_out_i : hi_q;
  assign bus.lo_o = bus.hilo_we_i[0] ? bus.lo_alu_out_i : lo_q;

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0]   trace_pc_p1;
  logic [AW-1:0] trace_wnum_p1;
  logic [DW-1:0] trace_wdata_p1;
  logic          vld_p1;

  // ---- trace stage p1: one cycle behind the commit edge ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1         <= 1'b0;
      trace_pc_p1    <= '0;
      trace_wnum_p1  <= '0;
      trace_wdata_p1 <= '0;
    end else begin
      vld_p1 <= commit;
      if (commit) begin
        trace_pc_p1    <= bus.pc_i;
        trace_wnum_p1  <= bus.writereg_i;
        trace_wdata_p1 <= wdata;
      end
    end
  end

  assign bus.dbg_pc_o    = trace_pc_p1;
  assign bus.dbg_wen_o   = {4{vld_p1}};
  assign bus.dbg_wnum_o  = trace_wnum_p1;
  assign bus.dbg_wdata_o = trace_wdata_p1;
`else
  logic unused_pc;
  assign unused_pc       = ^bus.pc_i;
  assign bus.dbg_pc_o    = '0;
  assign bus.dbg_wen_o   = '0;
  assign bus.dbg_wnum_o  = '0;
  assign bus.dbg_wdata_o = '0;
`endif
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed scenarios plus randomized traffic
// against an array-based architectural model of the GPR file, HI/LO and commit trace.
module tb_wb_regfile_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_regfile_stage_if #(.DW(32), .AW(5)) bus ();

  wb_regfile_stage #(.DW(32), .AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Architectural model
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic [31:0] e_pc, e_wdata;
  logic [3:0]  e_wen;
  logic [4:0]  e_wnum;

  function automatic logic [31:0] ref_wdata();
    return bus.memtoreg_i ? bus.finaldata_i : bus.result_i;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.regwrite_i && bus.writereg_i == a) return ref_wdata();
    return m_gpr[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 0; m_lo = 0; e_pc = 0; e_wdata = 0; e_wen = 0; e_wnum = 0;
  endtask

  task automatic model_edge();
    logic [31:0] wd;
    logic        wr;
    wd = ref_wdata();
    wr = bus.regwrite_i && (bus.writereg_i != 5'd0);
    if (wr) m_gpr[bus.writereg_i] = wd;
    if (bus.hilo_we_i[1]) m_hi = bus.hi_alu_out_i;
    if (bus.hilo_we_i[0]) m_lo = bus.lo_alu_out_i;
`ifdef WB_DEBUG_TRACE_EN
    e_wen = wr ? 4'hF : 4'h0;
    if (wr) begin
      e_pc = bus.pc_i; e_wnum = bus.writereg_i; e_wdata = wd;
    end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.memtoreg_i = 0; bus.regwrite_i = 0; bus.result_i = 0; bus.finaldata_i = 0;
    bus.writereg_i = 0; bus.pc_i = 0; bus.hi_alu_out_i = 0; bus.lo_alu_out_i = 0;
    bus.hilo_we_i = 0; bus.raddr1_i = 0; bus.raddr2_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.raddr1_i = 5'd3; bus.raddr2_i = 5'd0;
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got=%h exp=0", bus.rdata1_o); end
    n_cmp++; if (bus.rdata2_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 got=%h exp=0", bus.rdata2_o); end
    n_cmp++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_hilo got=%h/%h exp=0/0", bus.hi_o, bus.lo_o); end
    n_cmp++; if (bus.dbg_wen_o !== 4'h0 || bus.dbg_pc_o !== 32'h0 || bus.dbg_wdata_o !== 32'h0 || bus.dbg_wnum_o !== 5'h0) begin
      n_fail++; $display("FAIL reset_dbg got wen=%h pc=%h", bus.dbg_wen_o, bus.dbg_pc_o); end
    rst = 1'b0;
  endtask

  task automatic test_gpr_bypass();
    @(negedge clk);
    idle_inputs();
    bus.regwrite_i = 1; bus.writereg_i = 5'd5; bus.result_i = 32'h1234_5678;
    bus.pc_i = 32'h0000_0100; bus.raddr1_i = 5'd5;
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_r5 got=%h exp=12345678", bus.rdata1_o); end
    tick();
    n_cmp++; if (bus.dbg_wen_o !== e_wen || bus.dbg_pc_o !== e_pc || bus.dbg_wnum_o !== e_wnum || bus.dbg_wdata_o !== e_wdata) begin
      n_fail++; $display("FAIL trace_r5 got=%h/%h/%h/%h exp=%h/%h/%h/%h", bus.dbg_pc_o, bus.dbg_wen_o, bus.dbg_wnum_o,
                         bus.dbg_wdata_o, e_pc, e_wen, e_wnum, e_wdata); end
`ifdef WB_DEBUG_TRACE_EN
    n_cmp++; if (bus.dbg_wen_o !== 4'hF || bus.dbg_wdata_o !== 32'h1234_5678) begin
      n_fail++; $display("FAIL trace_r5_const got wen=%h wdata=%h exp=F/12345678", bus.dbg_wen_o, bus.dbg_wdata_o); end
`endif
    @(negedge clk);
    bus.regwrite_i = 0; bus.result_i = 32'h0;
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h1234_5678) begin n_fail++; $display("FAIL stored_r5 got=%h exp=12345678", bus.rdata1_o); end
    tick();
    n_cmp++; if (bus.dbg_wen_o !== 4'h0 || bus.dbg_pc_o !== e_pc || bus.dbg_wdata_o !== e_wdata) begin
      n_fail++; $display("FAIL trace_hold got wen=%h pc=%h exp=0/%h", bus.dbg_wen_o, bus.dbg_pc_o, e_pc); end
  endtask

  task automatic test_memtoreg();
    @(negedge clk);
    idle_inputs();
    bus.regwrite_i = 1; bus.memtoreg_i = 1; bus.writereg_i = 5'd7;
    bus.finaldata_i = 32'hDEAD_BEEF; bus.result_i = 32'h1; bus.pc_i = 32'h104;
    #1;
    n_cmp++; if (bus.wb_wdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL memtoreg_wdata got=%h exp=deadbeef", bus.wb_wdata_o); end
    tick();
    @(negedge clk);
    idle_inputs();
    bus.raddr2_i = 5'd7;
    #1;
    n_cmp++; if (bus.rdata2_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL memtoreg_r7 got=%h exp=deadbeef", bus.rdata2_o); end
  endtask

  task automatic test_r0();
    @(negedge clk);
    idle_inputs();
    bus.regwrite_i = 1; bus.writereg_i = 5'd0; bus.result_i = 32'hFFFF_FFFF; bus.raddr2_i = 5'd0;
    #1;
    n_cmp++; if (bus.rdata2_o !== 32'h0) begin n_fail++; $display("FAIL r0_bypass got=%h exp=0", bus.rdata2_o); end
    tick();
    n_cmp++; if (bus.dbg_wen_o !== 4'h0) begin n_fail++; $display("FAIL r0_trace_wen got=%h exp=0", bus.dbg_wen_o); end
    @(negedge clk);
    bus.regwrite_i = 0;
    #1;
    n_cmp++; if (bus.rdata2_o !== 32'h0) begin n_fail++; $display("FAIL r0_stored got=%h exp=0", bus.rdata2_o); end
    tick();
  endtask

  task automatic test_hilo();
    @(negedge clk);
    idle_inputs();
    bus.hilo_we_i = 2'b10; bus.hi_alu_out_i = 32'hA; bus.lo_alu_out_i = 32'hB;
    #1;
    n_cmp++; if (bus.hi_o !== 32'hA) begin n_fail++; $display("FAIL hi_bypass got=%h exp=a", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'h0) begin n_fail++; $display("FAIL lo_unchanged got=%h exp=0", bus.lo_o); end
    tick();
    @(negedge clk);
    bus.hilo_we_i = 2'b11; bus.hi_alu_out_i = 32'hC; bus.lo_alu_out_i = 32'hD;
    tick();
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (bus.hi_o !== 32'hC || bus.lo_o !== 32'hD) begin n_fail++; $display("FAIL hilo_both got=%h/%h exp=c/d", bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_random();
    logic [31:0] exp_r1, exp_r2, exp_hi, exp_lo, exp_wd;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      bus.memtoreg_i   = 1'($urandom);
      bus.regwrite_i   = ($urandom_range(0, 3) != 0);
      bus.result_i     = $urandom;
      bus.finaldata_i  = $urandom;
      bus.writereg_i   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.pc_i         = $urandom & 32'hFFFF_FFFC;
      bus.hi_alu_out_i = $urandom;
      bus.lo_alu_out_i = $urandom;
      bus.hilo_we_i    = 2'($urandom);
      bus.raddr1_i     = ($urandom_range(0, 2) == 0) ? bus.writereg_i : 5'($urandom);
      bus.raddr2_i     = ($urandom_range(0, 2) == 0) ? bus.writereg_i : 5'($urandom);
      #1;
      exp_wd = ref_wdata();
      exp_r1 = ref_read(bus.raddr1_i);
      exp_r2 = ref_read(bus.raddr2_i);
      exp_hi = bus.hilo_we_i[1] ? bus.hi_alu_out_i : m_hi;
      exp_lo = bus.hilo_we_i[0] ? bus.lo_alu_out_i : m_lo;
      n_cmp++; if (bus.wb_wdata_o !== exp_wd) begin n_fail++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", it, bus.wb_wdata_o, exp_wd); end
      n_cmp++; if (bus.rdata1_o !== exp_r1) begin n_fail++; $display("FAIL rnd_rdata1 it=%0d a=%0d got=%h exp=%h", it, bus.raddr1_i, bus.rdata1_o, exp_r1); end
      n_cmp++; if (bus.rdata2_o !== exp_r2) begin n_fail++; $display("FAIL rnd_rdata2 it=%0d a=%0d got=%h exp=%h", it, bus.raddr2_i, bus.rdata2_o, exp_r2); end
      n_cmp++; if (bus.hi_o !== exp_hi || bus.lo_o !== exp_lo) begin
        n_fail++; $display("FAIL rnd_hilo it=%0d got=%h/%h exp=%h/%h", it, bus.hi_o, bus.lo_o, exp_hi, exp_lo); end
      tick();
      n_cmp++; if (bus.dbg_wen_o !== e_wen || bus.dbg_pc_o !== e_pc || bus.dbg_wnum_o !== e_wnum || bus.dbg_wdata_o !== e_wdata) begin
        n_fail++; $display("FAIL rnd_trace it=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", it, bus.dbg_pc_o, bus.dbg_wen_o,
                           bus.dbg_wnum_o, bus.dbg_wdata_o, e_pc, e_wen, e_wnum, e_wdata); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle_inputs();
    bus.regwrite_i = 1; bus.writereg_i = 5'd9; bus.result_i = 32'h55;
    tick();
    @(negedge clk);
    bus.result_i = 32'h77; bus.raddr1_i = 5'd9;
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h77) begin n_fail++; $display("FAIL pre_reset_bypass got=%h exp=77", bus.rdata1_o); end
    #1;
    rst = 1'b1;
    idle_inputs();
    bus.raddr1_i = 5'd9;
    model_clear();
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h0) begin n_fail++; $display("FAIL async_reset_r9 got=%h exp=0", bus.rdata1_o); end
    n_cmp++; if (bus.dbg_wen_o !== 4'h0 || bus.dbg_pc_o !== 32'h0) begin n_fail++; $display("FAIL async_reset_dbg got=%h/%h exp=0/0", bus.dbg_wen_o, bus.dbg_pc_o); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h0) begin n_fail++; $display("FAIL post_reset_r9 got=%h exp=0", bus.rdata1_o); end
    tick();
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rdata1_o !== 32'h0) begin n_fail++; $display("FAIL post_reset_r9_later got=%h exp=0", bus.rdata1_o); end
  endtask

  initial begin
    test_reset();
    test_gpr_bypass();
    test_memtoreg();
    test_r0();
    test_hilo();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
